// File: rtl/inventory_pkg.sv
// -----------------------------------------------------------------------------
// inventory_pkg
//   Shared types for the inventory update transmit path.
//   - sid_width()  : stock-id width for a given stock count (minimum 1 bit)
//   - stock_id_t   : stock id for the default 4-stock configuration
//   - side_e       : fill side encoding (buy / sell)
//   - tx_state_e   : transmit FSM states (RUN / FLUSH / DONE)
// -----------------------------------------------------------------------------
package inventory_pkg;

    localparam int unsigned DEF_NUM_STOCKS = 4;

    // A single-stock build would otherwise produce a zero-width id.
    function automatic int unsigned sid_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(DEF_NUM_STOCKS)-1:0] stock_id_t;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } side_e;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick: the first requester at or after i_ptr,
//   wrapping modulo N.
//   Ports:
//     i_req    [N-1:0]   request vector
//     i_ptr    [IW-1:0]  search start position
//     o_grant  [N-1:0]   one-hot grant (all zero when no request)
//     o_idx    [IW-1:0]  index of the granted requester (0 when none)
//     o_any    1         at least one request is present
// -----------------------------------------------------------------------------
module rr_arbiter
    import inventory_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = sid_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        logic [IW-1:0] w_cand;
        // NOTE: every output of a combinational block gets a default before any
        // conditional assignment; a path that skips an assignment infers a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_cand = IW'((int'(i_ptr) + k) % int'(N));
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/inventory_update_tx.sv
// -----------------------------------------------------------------------------
// inventory_update_tx
//   Transmit side of the inventory update interface. Fill reports are netted
//   per stock into buy/sell accumulators; one batched update per cycle is sent
//   to the inventory block, round-robin over stocks with pending quantity.
//   A flush request stops intake until every accumulator has drained.
//   Ports:
//     i_clk, i_reset      clock, synchronous active-high reset
//     i_fill_valid        fill report valid
//     o_fill_ready        fill accepted on valid & ready (combinational)
//     i_fill_stock_id     stock of the fill
//     i_fill_side         0 = buy, 1 = sell
//     i_fill_qty          filled quantity (0 is accepted and ignored)
//     i_inv_hold          inventory bus reserved next cycle: launch nothing
//     i_flush             drain request (level, sampled in RUN)
//     o_flush_done        one-cycle pulse when the drain completes
//     o_stock_id          stock id of the update
//     o_buy_quantity      netted buy quantity of the batch
//     o_ask_quantity      netted sell quantity of the batch
//     o_data_valid        update strobe, one cycle per batch
// -----------------------------------------------------------------------------
module inventory_update_tx
    import inventory_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned NUM_STOCKS    = 4,
    parameter int unsigned MAX_BATCH_QTY = 65535,
    parameter int unsigned SIDW          = sid_width(NUM_STOCKS)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fill_valid,
    output logic                  o_fill_ready,
    input  logic [SIDW-1:0]       i_fill_stock_id,
    input  logic                  i_fill_side,
    input  logic [DATA_WIDTH-1:0] i_fill_qty,
    input  logic                  i_inv_hold,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic [SIDW-1:0]       o_stock_id,
    output logic [DATA_WIDTH-1:0] o_buy_quantity,
    output logic [DATA_WIDTH-1:0] o_ask_quantity,
    output logic                  o_data_valid
);

    localparam logic [DATA_WIDTH:0] MAX_QTY = (DATA_WIDTH+1)'(MAX_BATCH_QTY);
    localparam logic [SIDW-1:0]     LAST_ID = SIDW'(NUM_STOCKS - 1);

    // ------------------------------------------------------------------ state
    tx_state_e             r_state;
    tx_state_e             w_state_next;

    logic [DATA_WIDTH-1:0] r_acc_buy  [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] r_acc_sell [NUM_STOCKS];
    logic [SIDW-1:0]       r_rr_ptr;

    logic                  r_data_valid;
    logic [SIDW-1:0]       r_stock_id;
    logic [DATA_WIDTH-1:0] r_buy_quantity;
    logic [DATA_WIDTH-1:0] r_ask_quantity;

    // ------------------------------------------------------------- fill intake
    side_e                 w_side;
    logic [DATA_WIDTH-1:0] w_acc_cur;
    logic [DATA_WIDTH:0]   w_acc_sum;
    logic                  w_accept;

    assign w_side    = side_e'(i_fill_side);
    assign w_acc_cur = (w_side == SIDE_SELL) ? r_acc_sell[i_fill_stock_id]
                                             : r_acc_buy[i_fill_stock_id];
    // One extra bit so the cap comparison cannot be fooled by wrap-around.
    assign w_acc_sum = {1'b0, w_acc_cur} + {1'b0, i_fill_qty};

    // An empty accumulator always takes the fill, even one larger than the cap,
    // so a single oversized fill can never deadlock the port.
    assign o_fill_ready = (r_state == RUN) &&
                          ((w_acc_cur == '0) || (w_acc_sum <= MAX_QTY));
    assign w_accept     = i_fill_valid && o_fill_ready;

    // --------------------------------------------------------------- scheduler
    logic [NUM_STOCKS-1:0] w_req;
    logic [NUM_STOCKS-1:0] w_grant;
    logic [SIDW-1:0]       w_gnt_idx;
    logic                  w_any;
    logic                  w_launch;
    logic [SIDW-1:0]       w_ptr_next;

    always_comb begin
        for (int s = 0; s < int'(NUM_STOCKS); s++) begin
            w_req[s] = (r_acc_buy[s] != '0) || (r_acc_sell[s] != '0);
        end
    end

    rr_arbiter #(
        .N  (NUM_STOCKS),
        .IW (SIDW)
    ) u_rr_arbiter (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    assign w_launch   = w_any && !i_inv_hold;
    assign w_ptr_next = (w_gnt_idx == LAST_ID) ? '0 : w_gnt_idx + SIDW'(1);

    // ----------------------------------------------- accumulators and outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: the accumulators are real state whose reset value matters
            // (pending quantity must be discarded), so every entry is reset
            // here rather than left to power-up contents as a plain RAM would be.
            for (int s = 0; s < int'(NUM_STOCKS); s++) begin
                r_acc_buy[s]  <= '0;
                r_acc_sell[s] <= '0;
            end
            r_rr_ptr       <= '0;
            r_data_valid   <= 1'b0;
            r_stock_id     <= '0;
            r_buy_quantity <= '0;
            r_ask_quantity <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // right-hand side reads the pre-edge value; the collision case
            // below depends on that.
            r_data_valid <= w_launch;
            if (w_launch) begin
                r_stock_id     <= w_gnt_idx;
                r_buy_quantity <= r_acc_buy[w_gnt_idx];
                r_ask_quantity <= r_acc_sell[w_gnt_idx];
                r_rr_ptr       <= w_ptr_next;
            end

            for (int s = 0; s < int'(NUM_STOCKS); s++) begin
                if (w_launch && w_grant[s]) begin
                    r_acc_buy[s]  <= '0;
                    r_acc_sell[s] <= '0;
                end
                // A fill landing on the stock being emitted starts a fresh
                // batch holding exactly that fill; the emitted batch is the
                // pre-add snapshot captured above.
                if (w_accept && (i_fill_stock_id == SIDW'(s))) begin
                    if (w_side == SIDE_SELL) begin
                        r_acc_sell[s] <= (w_launch && w_grant[s]) ? i_fill_qty
                                                                  : r_acc_sell[s] + i_fill_qty;
                    end else begin
                        r_acc_buy[s]  <= (w_launch && w_grant[s]) ? i_fill_qty
                                                                  : r_acc_buy[s] + i_fill_qty;
                    end
                end
            end
        end
    end

    // --------------------------------------------------------------- flush FSM
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (i_flush) w_state_next = FLUSH;
            // No intake in FLUSH, so empty accumulators also mean nothing is
            // launched this cycle; a hold simply keeps them non-empty longer.
            FLUSH:   if (!w_any) w_state_next = DONE;
            DONE:    w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    // ----------------------------------------------------------------- outputs
    assign o_flush_done   = (r_state == DONE);
    assign o_data_valid   = r_data_valid;
    assign o_stock_id     = r_stock_id;
    assign o_buy_quantity = r_buy_quantity;
    assign o_ask_quantity = r_ask_quantity;

endmodule
